shiftrows_pipe: RTL and testbench

- Parametrised ShiftRows / InvShiftRows stage for the AES/Rijndael datapath.
- Supports block widths of Nb = 4, 6 or 8 columns.
- Selects forward or inverse per transaction.
- Uses a valid/ready handshake with a one-deep output register and full throughput, so the round controller can stall it without losing data.

---
 rtl/shiftrows_pipe.sv | 103 ++++++++++
 tb/tb_shiftrows_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftrows_pipe.sv
// ShiftRows / InvShiftRows stage for a Rijndael datapath with Nb = 4, 6 or 8 columns.
// The byte permutation is pure wiring, captured in a one-deep valid/ready output register.
module shiftrows_pipe #(
  parameter int NB = 4,
  parameter int W  = 32 * NB
) (
  input  logic         int_osc,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [W-1:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_state,
  output logic         out_inv,
  output logic         rowsdone
);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shiftrows_pipe: NB must be 4, 6 or 8");
  end

  // Rijndael uses larger shifts on rows 2 and 3 only for the 256-bit block.
  function automatic int row_off(input int r);
    int off;
    case (r)
      0:       off = 0;
      1:       off = 1;
      2:       off = (NB == 8) ? 3 : 2;
      3:       off = (NB == 8) ? 4 : 3;
      default: off = 0;
    endcase
    return off;
  endfunction

  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] s, input logic inv);
    logic [W-1:0] res;
    int           off;
    int           src;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      off = row_off(r);
      for (int c = 0; c < NB; c++) begin
        if (inv) begin
          src = (c - off + NB) % NB;
        end else begin
          src = (c + off) % NB;
        end
        res[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*src+r) -: 8];
      end
    end
    return res;
  endfunction

  logic [W-1:0] out_state_q, out_state_d;
  logic         out_inv_q, out_inv_d;
  logic         out_valid_q, out_valid_d;
  logic         rowsdone_q, rowsdone_d;
  logic         accept_s;

  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;

  // Next-state of the output register: load on accept, clear on drain, hold on stall.
  always_comb begin
    out_state_d = out_state_q;
    out_inv_d   = out_inv_q;
    out_valid_d = out_valid_q;
    rowsdone_d  = 1'b0;
    if (accept_s) begin
      out_state_d = shift_rows(in_state, in_inv);
      out_inv_d   = in_inv;
      out_valid_d = 1'b1;
      rowsdone_d  = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge int_osc) begin
    if (reset) begin
      out_state_q <= '0;
      out_inv_q   <= 1'b0;
      out_valid_q <= 1'b0;
      rowsdone_q  <= 1'b0;
    end else begin
      out_state_q <= out_state_d;
      out_inv_q   <= out_inv_d;
      out_valid_q <= out_valid_d;
      rowsdone_q  <= rowsdone_d;
    end
  end

  assign out_state = out_state_q;
  assign out_inv   = out_inv_q;
  assign out_valid = out_valid_q;
  assign rowsdone  = rowsdone_q;

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Scoreboard bench for shiftrows_pipe: NB=4 instance under handshake traffic,
// NB=6 and NB=8 instances for known-answer and round-trip checks.
module tb_shiftrows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  // NB = 4 instance
  logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv, rowsdone;
  logic [127:0] in_state, out_state;
  // NB = 6 instance
  logic         v6_in_valid, v6_in_ready, v6_in_inv, v6_out_valid, v6_out_inv, v6_rowsdone;
  logic [191:0] v6_in_state, v6_out_state;
  // NB = 8 instance
  logic         v8_in_valid, v8_in_ready, v8_in_inv, v8_out_valid, v8_out_inv, v8_rowsdone;
  logic [255:0] v8_in_state, v8_out_state;

  shiftrows_pipe #(.NB(4)) dut4 (
    .int_osc(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_inv(out_inv), .rowsdone(rowsdone));

  shiftrows_pipe #(.NB(6)) dut6 (
    .int_osc(clk), .reset(reset), .in_valid(v6_in_valid), .in_ready(v6_in_ready), .in_inv(v6_in_inv),
    .in_state(v6_in_state), .out_valid(v6_out_valid), .out_ready(1'b1), .out_state(v6_out_state),
    .out_inv(v6_out_inv), .rowsdone(v6_rowsdone));

  shiftrows_pipe #(.NB(8)) dut8 (
    .int_osc(clk), .reset(reset), .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_inv(v8_in_inv),
    .in_state(v8_in_state), .out_valid(v8_out_valid), .out_ready(1'b1), .out_state(v8_out_state),
    .out_inv(v8_out_inv), .rowsdone(v8_rowsdone));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: rotate each row one column at a time, off_r times.
  function automatic logic [255:0] ref_shift(input logic [255:0] s, input int nb, input logic inv);
    logic [7:0]   b [0:31];
    logic [7:0]   row [0:7];
    logic [7:0]   t;
    logic [255:0] res;
    int           offs [0:3];
    if (nb == 8) begin
      offs = '{0, 1, 3, 4};
    end else begin
      offs = '{0, 1, 2, 3};
    end
    for (int i = 0; i < 4 * nb; i++) b[i] = s[nb*32-1-8*i -: 8];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < nb; c++) row[c] = b[4*c+r];
      for (int k = 0; k < offs[r]; k++) begin
        if (!inv) begin
          t = row[0];
          for (int c = 0; c < nb - 1; c++) row[c] = row[c+1];
          row[nb-1] = t;
        end else begin
          t = row[nb-1];
          for (int c = nb - 1; c > 0; c--) row[c] = row[c-1];
          row[0] = t;
        end
      end
      for (int c = 0; c < nb; c++) b[4*c+r] = row[c];
    end
    res = '0;
    for (int i = 0; i < 4 * nb; i++) res[nb*32-1-8*i -: 8] = b[i];
    return res;
  endfunction

  // Scoreboard / protocol monitor for the NB = 4 instance, sampled on the falling edge.
  logic [128:0] sb [$];
  logic [128:0] exp_item;
  logic [255:0] exp_full;
  logic         mon_on = 1'b0;
  logic         have_prev = 1'b0;
  logic         exp_rd, prev_stall;
  logic [127:0] prev_state;
  logic         prev_inv;
  int           results_cnt = 0;
  int           rd_cnt = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (have_prev) begin
        check_eq("rowsdone_vs_accept", rowsdone, exp_rd);
        if (prev_stall) begin
          check_eq("stall_hold_state", out_state, prev_state);
          check_eq("stall_hold_inv", out_inv, prev_inv);
          check_eq("stall_hold_valid", out_valid, 1'b1);
        end
      end
      if (rowsdone) rd_cnt++;
      if (reset) begin
        sb.delete();
        exp_rd     = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          check_eq("sb_has_item", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            exp_item = sb.pop_front();
            check_eq("sb_state", out_state, exp_item[127:0]);
            check_eq("sb_inv", out_inv, exp_item[128]);
          end
          results_cnt++;
        end
        if (in_valid && in_ready) begin
          exp_full = ref_shift({128'd0, in_state}, 4, in_inv);
          sb.push_back({in_inv, exp_full[127:0]});
        end
        exp_rd     = in_valid && in_ready;
        prev_stall = out_valid && !out_ready;
        prev_state = out_state;
        prev_inv   = out_inv;
      end
      have_prev = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  int           r0, d0;
  logic [191:0] s6, r6;
  logic [255:0] s8, r8, tmp;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_inv = 1'b0; in_state = '0; out_ready = 1'b0;
    v6_in_valid = 1'b0; v6_in_inv = 1'b0; v6_in_state = '0;
    v8_in_valid = 1'b0; v8_in_inv = 1'b0; v8_in_state = '0;
    tick(); tick();
    mon_on = 1'b1;
    tick();
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_rowsdone", rowsdone, 1'b0);
    check_eq("rst_out_state", out_state, 128'd0);
    check_eq("rst_out_inv", out_inv, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;

    // FIPS-197 forward and inverse
    in_valid = 1'b1; in_inv = 1'b0; in_state = FIPS_IN; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("fips_fwd_valid", out_valid, 1'b1);
    check_eq("fips_fwd_state", out_state, FIPS_OUT);
    check_eq("fips_fwd_inv", out_inv, 1'b0);
    check_eq("fips_fwd_rowsdone", rowsdone, 1'b1);
    tick();
    check_eq("fips_fwd_rd_pulse", rowsdone, 1'b0);
    check_eq("fips_fwd_drained", out_valid, 1'b0);
    in_valid = 1'b1; in_inv = 1'b1; in_state = FIPS_OUT;
    tick();
    in_valid = 1'b0;
    check_eq("fips_inv_state", out_state, FIPS_IN);
    check_eq("fips_inv_inv", out_inv, 1'b1);
    tick();

    // NB = 6 and NB = 8 forward, then round trip
    for (int i = 0; i < 24; i++) s6[191-8*i -: 8] = 8'(i);
    for (int i = 0; i < 32; i++) s8[255-8*i -: 8] = 8'(i);
    v6_in_valid = 1'b1; v6_in_inv = 1'b0; v6_in_state = s6;
    v8_in_valid = 1'b1; v8_in_inv = 1'b0; v8_in_state = s8;
    tick();
    v6_in_valid = 1'b0; v8_in_valid = 1'b0;
    check_eq("nb6_valid", v6_out_valid, 1'b1);
    check_eq("nb6_col0", v6_out_state[191 -: 32], 32'h00050a0f);
    tmp = ref_shift({64'd0, s6}, 6, 1'b0);
    check_eq("nb6_fwd", v6_out_state, tmp[191:0]);
    check_eq("nb6_rowsdone", v6_rowsdone, 1'b1);
    check_eq("nb8_valid", v8_out_valid, 1'b1);
    check_eq("nb8_col0", v8_out_state[255 -: 32], 32'h00050e13);
    check_eq("nb8_fwd", v8_out_state, ref_shift(s8, 8, 1'b0));
    r6 = v6_out_state; r8 = v8_out_state;
    v6_in_valid = 1'b1; v6_in_inv = 1'b1; v6_in_state = r6;
    v8_in_valid = 1'b1; v8_in_inv = 1'b1; v8_in_state = r8;
    tick();
    v6_in_valid = 1'b0; v8_in_valid = 1'b0;
    check_eq("nb6_roundtrip", v6_out_state, s6);
    check_eq("nb6_inv_flag", v6_out_inv, 1'b1);
    check_eq("nb8_roundtrip", v8_out_state, s8);
    check_eq("nb8_inv_flag", v8_out_inv, 1'b1);
    tick();

    // Backpressure: three transfers with a four-cycle stall after the first
    r0 = results_cnt; d0 = rd_cnt;
    in_valid = 1'b1; in_inv = 1'b0; in_state = {4{$urandom}}; out_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_inv = 1'(k);
      #1;
      check_eq("bp_in_ready_low", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1; in_inv = 1'b1; in_state = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_inv = 1'b0; in_state = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check_eq("bp_results", results_cnt - r0, 3);
    check_eq("bp_rowsdone", rd_cnt - d0, 3);

    // Full throughput with alternating direction
    r0 = results_cnt;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_inv = 1'(k);
      in_state = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check_eq("tp_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    check_eq("tp_results", results_cnt - r0, 10);

    // Reset while a result is stalled
    in_valid = 1'b1; in_inv = 1'b0; in_state = {$urandom, $urandom, $urandom, $urandom}; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check_eq("rs_stalled_valid", out_valid, 1'b1);
    r0 = results_cnt;
    reset = 1'b1;
    tick();
    check_eq("rs_out_valid", out_valid, 1'b0);
    check_eq("rs_rowsdone", rowsdone, 1'b0);
    check_eq("rs_in_ready", in_ready, 1'b1);
    reset = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    check_eq("rs_no_result", results_cnt - r0, 0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_inv    = 1'($urandom_range(0, 1));
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check_eq("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
